// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Hazard / stall controller for the 5-stage MIPS pipeline.
//   - Detects load-use hazards between the ID instruction and a load in EX
//     (and a load in MEM when there is no MEM->EX forwarding path).
//   - Tracks an in-flight multi-cycle multiply/divide op that owns HI/LO.
//   - Drives PC / IF-ID write enables and the ID/EX bubble, and keeps a
//     saturating count of stalled cycles.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   id_rs, id_rt    source registers of the ID instruction
//   id_uses_rs/rt   ID instruction actually reads rs / rt
//   id_mdu_start    ID instruction is mult/multu/div/divu
//   id_reads_hilo   ID instruction is mfhi/mflo
//   id_flush        ID instruction is being squashed
//   ex_mem_read     EX instruction is a load, destination ex_rd
//   mem_mem_read    MEM instruction is a load, destination mem_rd
//   pc_write        PC update enable
//   ifid_write      IF/ID register write enable
//   idex_bubble     insert a NOP into ID/EX
//   mdu_busy        MDU op in flight
//   stall_cycles    saturating stalled-cycle counter
module pipeline_stall_ctrl #(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_LATENCY       = 4,
  parameter int MDU_CW            = 4,
  parameter int PERF_W            = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_mdu_start,
  input  logic              id_reads_hilo,
  input  logic              id_flush,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  localparam logic [MDU_CW-1:0] LAT_CNT  = MDU_CW'(MDU_LATENCY);
  localparam logic [MDU_CW-1:0] CNT_LAST = MDU_CW'(1);
  // Without MEM->EX forwarding a load still in MEM is also a hazard.
  localparam bit USE_MEM_HZ = (LOAD_STALL_CYCLES == 2);

  mdu_state_t        state;
  logic [MDU_CW-1:0] cnt;

  logic ld_ex;
  logic ld_mem_raw;
  logic ld_mem;
  logic load_hz;
  logic mdu_hz;
  logic stall;
  logic issue;

  // Register $0 is hardwired to zero, so it can never be a true dependency.
  function automatic logic hit(input logic [REG_AW-1:0] r,
                               input logic [REG_AW-1:0] d);
    return (r == d) && (d != '0);
  endfunction

  // Hazard detection (combinational)
  assign ld_ex      = ex_mem_read  & ((id_uses_rs & hit(id_rs, ex_rd)) |
                                      (id_uses_rt & hit(id_rt, ex_rd)));
  assign ld_mem_raw = mem_mem_read & ((id_uses_rs & hit(id_rs, mem_rd)) |
                                      (id_uses_rt & hit(id_rt, mem_rd)));
  assign ld_mem     = USE_MEM_HZ ? ld_mem_raw : 1'b0;
  assign load_hz    = ld_ex | ld_mem;

  assign mdu_busy = (state == BUSY);
  assign mdu_hz   = mdu_busy & (id_reads_hilo | id_mdu_start);

  // A squashed instruction is discarded anyway, so it never holds the pipe.
  assign stall = (load_hz | mdu_hz) & ~id_flush;
  assign issue = id_mdu_start & ~stall & ~id_flush;

  // While reset is held the pipe must keep flowing whatever the inputs say.
  assign pc_write    = ~stall | rst;
  assign ifid_write  = ~stall | rst;
  assign idex_bubble =  stall & ~rst;

  // MDU occupancy FSM: busy for MDU_LATENCY cycles after an accepted issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state <= BUSY;
            cnt   <= LAT_CNT;
          end
        end
        BUSY: begin
          // A flush does not cancel the op; only the countdown ends it.
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_LAST;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Stalled-cycle counter, sticks at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rs, id_uses_rt, id_mdu_start, id_reads_hilo, id_flush;
  logic       ex_mem_read, mem_mem_read;

  // Instance A: MEM forwarding present, 4-cycle MDU, 32-bit counter
  logic        pcw_a, ifw_a, bub_a, busy_a;
  logic [31:0] cnt_a;
  // Instance B: no MEM forwarding, 1-cycle MDU, 4-bit counter
  logic        pcw_b, ifw_b, bub_b, busy_b;
  logic [3:0]  cnt_b;

  pipeline_stall_ctrl #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .MDU_LATENCY(4),
                        .MDU_CW(4), .PERF_W(32)) u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .id_reads_hilo(id_reads_hilo),
    .id_flush(id_flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .pc_write(pcw_a), .ifid_write(ifw_a), .idex_bubble(bub_a),
    .mdu_busy(busy_a), .stall_cycles(cnt_a));

  pipeline_stall_ctrl #(.REG_AW(5), .LOAD_STALL_CYCLES(2), .MDU_LATENCY(1),
                        .MDU_CW(4), .PERF_W(4)) u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .id_reads_hilo(id_reads_hilo),
    .id_flush(id_flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .pc_write(pcw_b), .ifid_write(ifw_b), .idex_bubble(bub_b),
    .mdu_busy(busy_b), .stall_cycles(cnt_b));

  typedef struct packed {
    logic        pcw_a, ifw_a, bub_a, busy_a;
    logic [31:0] cnt_a;
    logic        pcw_b, ifw_b, bub_b, busy_b;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: the MDU is busy in cycles (issue, issue+LAT]; counters
  // are plain integers clamped at the counter maximum.
  int     cyc   = 0;
  int     end_a = -1;
  int     end_b = -1;
  longint mcnt_a = 0;
  int     mcnt_b = 0;

  function automatic logic hit(input logic [4:0] r, input logic [4:0] d);
    return (r == d) && (d != 5'd0);
  endfunction

  function automatic logic m_stall(input int lsc, input logic busy);
    logic ld_ex, ld_mem, mdu;
    ld_ex  = ex_mem_read && ((id_uses_rs && hit(id_rs, ex_rd)) ||
                             (id_uses_rt && hit(id_rt, ex_rd)));
    ld_mem = (lsc == 2) && mem_mem_read &&
             ((id_uses_rs && hit(id_rs, mem_rd)) ||
              (id_uses_rt && hit(id_rt, mem_rd)));
    mdu    = busy && (id_reads_hilo || id_mdu_start);
    return (ld_ex || ld_mem || mdu) && !id_flush;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_mdu_start = 0; id_reads_hilo = 0;
    id_flush = 0; ex_mem_read = 0; mem_mem_read = 0;
  endtask

  // Called once per cycle after inputs settle: push the expected outputs for
  // this cycle, then advance the model across the coming clock edge.
  task automatic eval();
    exp_t e;
    logic ba, bb, sa, sb;
    if (rst) begin
      end_a = -1; end_b = -1; mcnt_a = 0; mcnt_b = 0;
    end
    ba = !rst && (cyc <= end_a);
    bb = !rst && (cyc <= end_b);
    sa = !rst && m_stall(1, ba);
    sb = !rst && m_stall(2, bb);
    e.pcw_a = !sa; e.ifw_a = !sa; e.bub_a = sa; e.busy_a = ba;
    e.cnt_a = mcnt_a[31:0];
    e.pcw_b = !sb; e.ifw_b = !sb; e.bub_b = sb; e.busy_b = bb;
    e.cnt_b = 4'(mcnt_b);
    exp_q.push_back(e);
    if (!rst) begin
      if (id_mdu_start && !sa && !id_flush) end_a = cyc + 4;
      if (id_mdu_start && !sb && !id_flush) end_b = cyc + 1;
      if (sa && mcnt_a < 64'hFFFF_FFFF) mcnt_a++;
      if (sb && mcnt_b < 15) mcnt_b++;
    end
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle-time %0t: got %0h expected %0h", name, $time,
               act, exp);
    end
  endtask

  // Monitor: every cycle the DUTs present outputs; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a_pc_write",     {31'd0, pcw_a},  {31'd0, e.pcw_a});
        check("a_ifid_write",   {31'd0, ifw_a},  {31'd0, e.ifw_a});
        check("a_idex_bubble",  {31'd0, bub_a},  {31'd0, e.bub_a});
        check("a_mdu_busy",     {31'd0, busy_a}, {31'd0, e.busy_a});
        check("a_stall_cycles", cnt_a,           e.cnt_a);
        check("b_pc_write",     {31'd0, pcw_b},  {31'd0, e.pcw_b});
        check("b_ifid_write",   {31'd0, ifw_b},  {31'd0, e.ifw_b});
        check("b_idex_bubble",  {31'd0, bub_b},  {31'd0, e.bub_b});
        check("b_mdu_busy",     {31'd0, busy_b}, {31'd0, e.busy_b});
        check("b_stall_cycles", {28'd0, cnt_b},  {28'd0, e.cnt_b});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit %0d",
             $time, 2_000_000);
    $fatal(1, "watchdog");
  end

  task automatic load_use(input logic [4:0] rd, input logic use_rs);
    next_cycle();
    ex_mem_read = 1; ex_rd = rd; id_rs = 5'd8; id_uses_rs = use_rs; eval();
  endtask

  initial begin
    rst = 1;
    next_cycle(); eval();           // reset state, with a hazard on the inputs
    next_cycle(); ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1; eval();
    next_cycle(); rst = 0; eval();

    // Load-use: real hazard, $0 destination, rs not read
    load_use(5'd8, 1'b1);
    load_use(5'd0, 1'b1);
    load_use(5'd8, 1'b0);

    // Load in MEM: only the no-forwarding instance stalls
    next_cycle(); mem_mem_read = 1; mem_rd = 9; id_rt = 9; id_uses_rt = 1; eval();

    // mult then mfhi
    next_cycle(); id_mdu_start = 1; eval();
    for (int i = 0; i < 6; i++) begin next_cycle(); id_reads_hilo = 1; eval(); end

    // Back-to-back mult
    next_cycle(); id_mdu_start = 1; eval();
    for (int i = 0; i < 8; i++) begin next_cycle(); id_mdu_start = 1; eval(); end
    for (int i = 0; i < 5; i++) begin next_cycle(); eval(); end

    // Flush beats a load hazard; flush during BUSY keeps the schedule
    next_cycle(); ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    id_flush = 1; eval();
    next_cycle(); id_mdu_start = 1; eval();
    for (int i = 0; i < 6; i++) begin
      next_cycle(); id_flush = 1; id_reads_hilo = 1; eval();
    end

    // Reset mid-BUSY, held with hazards on the inputs, then mfhi
    next_cycle(); id_mdu_start = 1; eval();
    next_cycle(); id_reads_hilo = 1; eval();
    next_cycle(); rst = 1; id_reads_hilo = 1; ex_mem_read = 1; ex_rd = 3;
    id_rt = 3; id_uses_rt = 1; eval();
    next_cycle(); id_reads_hilo = 1; eval();
    next_cycle(); rst = 0; id_reads_hilo = 1; eval();

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      next_cycle(); ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1; eval();
    end

    // Randomized traffic over a small register set so hits are common
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (rst) rst = ($urandom_range(0, 1) == 0);
      else     rst = ($urandom_range(0, 199) == 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      mem_rd        = 5'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom_range(0, 1));
      id_uses_rt    = 1'($urandom_range(0, 1));
      ex_mem_read   = ($urandom_range(0, 2) == 0);
      mem_mem_read  = ($urandom_range(0, 2) == 0);
      id_mdu_start  = ($urandom_range(0, 5) == 0);
      id_reads_hilo = ($urandom_range(0, 3) == 0);
      id_flush      = ($urandom_range(0, 7) == 0);
      eval();
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
